// File: rtl/adder_rr_sched.sv
// adder_rr_sched: round-robin scheduler sharing one registered adder
// (sum = x + y + cin) between NREQ requesters. Results return on a single
// response channel carrying the sum, the producing requester id and a zero flag.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high. Requesters hold req_valid and operands stable until their req_ready bit
// is seen. The response holds rsp_sum/rsp_id/rsp_zero stable while
// rsp_valid=1 and rsp_ready=0. req_ready is never a function of rsp_valid
// alone; it only opens when the output register is free or being drained.
module adder_rr_sched #(
  parameter int NREQ   = 4,
  parameter int WIDTH  = 8,
  parameter int SWIDTH = WIDTH + 1,
  parameter int IDW    = 2,
  parameter int CNTW   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_x,
  input  logic [NREQ*WIDTH-1:0] req_y,
  input  logic [NREQ-1:0]       req_cin,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [SWIDTH-1:0]     rsp_sum,
  output logic [IDW-1:0]        rsp_id,
  output logic                  rsp_zero,
  output logic                  busy,
  output logic [CNTW-1:0]       op_count,
  output logic                  state_dbg
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [IDW-1:0]      ptr_q, ptr_d;
  logic [SWIDTH-1:0]   sum_q, sum_d;
  logic [IDW-1:0]      id_q, id_d;
  logic                zero_q, zero_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;

  logic                can_issue;
  logic                any_valid;
  logic                grant;
  logic                accept;
  logic [IDW-1:0]      win;
  logic [IDW-1:0]      idx;
  logic [WIDTH-1:0]    x_w;
  logic [WIDTH-1:0]    y_w;
  logic                cin_w;
  logic [SWIDTH-1:0]   sum_new;

  // Output register is free when empty, or when it is being drained this cycle.
  assign can_issue = (state_q == EMPTY) || ((state_q == FULL) && rsp_ready);
  assign grant     = can_issue && any_valid && !rst;
  assign accept    = (state_q == FULL) && rsp_ready;

  // Round-robin scan starting at ptr, wrapping modulo NREQ; first valid wins.
  always_comb begin
    any_valid = 1'b0;
    win       = '0;
    idx       = ptr_q;
    for (int k = 0; k < NREQ; k++) begin
      if (!any_valid && req_valid[idx]) begin
        any_valid = 1'b1;
        win       = idx;
      end
      idx = (idx == IDW'(NREQ - 1)) ? '0 : idx + 1'b1;
    end
  end

  // Select the winner's operands and form the full-width sum.
  always_comb begin
    x_w   = '0;
    y_w   = '0;
    cin_w = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == IDW'(i)) begin
        x_w   = req_x[i*WIDTH +: WIDTH];
        y_w   = req_y[i*WIDTH +: WIDTH];
        cin_w = req_cin[i];
      end
    end
    sum_new = SWIDTH'(x_w) + SWIDTH'(y_w) + SWIDTH'(cin_w);
  end

  // Grant vector: one-hot on the winner, zero otherwise (and during reset).
  always_comb begin
    req_ready = '0;
    if (grant) begin
      req_ready = NREQ'(1) << win;
    end
  end

  // Next-state: drain on accept, refill on grant (grant wins the state update).
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sum_d   = sum_q;
    id_d    = id_q;
    zero_d  = zero_q;
    cnt_d   = cnt_q;
    if (accept) begin
      cnt_d   = cnt_q + 1'b1;
      state_d = EMPTY;
    end
    if (grant) begin
      sum_d   = sum_new;
      zero_d  = (sum_new == '0);
      id_d    = win;
      ptr_d   = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
      state_d = FULL;
    end
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      sum_q   <= '0;
      id_q    <= '0;
      zero_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sum_q   <= sum_d;
      id_q    <= id_d;
      zero_q  <= zero_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rsp_valid = (state_q == FULL);
  assign rsp_sum   = sum_q;
  assign rsp_id    = id_q;
  assign rsp_zero  = zero_q;
  assign op_count  = cnt_q;
  assign busy      = rsp_valid || (|req_valid);
  assign state_dbg = state_q;

endmodule
